// File: rtl/asansor_kontrol.sv
// asansor_kontrol: collective (SCAN) elevator controller.
// Latches floor requests, moves one floor every HAREKET_SURE cycles, keeps the
// door open for KAPI_SURE cycles at each stop and only reverses direction once
// nothing is left ahead of the car.
module asansor_kontrol #(
  parameter int KAT_SAYISI   = 4,
  parameter int KAT_W        = 2,
  parameter int HAREKET_SURE = 4,
  parameter int KAPI_SURE    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KAT_SAYISI-1:0] buton,
  output logic [KAT_W-1:0]      mevcut_kat,
  output logic [KAT_W-1:0]      durdugu_kat,
  output logic                  hareket,
  output logic                  yon,
  output logic                  kapi_acik,
  output logic [KAT_SAYISI-1:0] bekleyen
);

  localparam logic [1:0] BOSTA   = 2'd0;
  localparam logic [1:0] HAREKET = 2'd1;
  localparam logic [1:0] KAPI    = 2'd2;

  // The shared timer must hold the larger of the two reload values.
  localparam int T_MAX   = (HAREKET_SURE > KAPI_SURE) ? HAREKET_SURE : KAPI_SURE;
  localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TIMER_W-1:0] HAREKET_YUK = TIMER_W'(HAREKET_SURE - 1);
  localparam logic [TIMER_W-1:0] KAPI_YUK    = TIMER_W'(KAPI_SURE - 1);

  logic [1:0]            durum, durum_d;
  logic [TIMER_W-1:0]    timer, timer_d;
  logic [KAT_W-1:0]      kat_q, kat_d;
  logic [KAT_W-1:0]      durak_q, durak_d;
  logic                  yon_q, yon_d;
  logic [KAT_SAYISI-1:0] bekleyen_q;

  logic [KAT_SAYISI-1:0] istek;
  logic [KAT_SAYISI-1:0] temizle;
  logic [KAT_SAYISI-1:0] kat_bit;
  logic [KAT_SAYISI-1:0] yeni_bit;
  logic [KAT_W-1:0]      yeni_kat;
  logic                  ust_var, alt_var, ileri_var;
  logic                  burada, yeni_burada, buton_burada;

  // A raw press acts on the same edge that latches it, so decisions use the
  // union of latched and live requests.
  assign istek    = bekleyen_q | buton;
  assign yeni_kat = yon_q ? (kat_q + KAT_W'(1)) : (kat_q - KAT_W'(1));

  // Decode floor positions and scan for requests above, below and beyond the next floor.
  always_comb begin
    kat_bit   = '0;
    yeni_bit  = '0;
    ust_var   = 1'b0;
    alt_var   = 1'b0;
    ileri_var = 1'b0;
    for (int i = 0; i < KAT_SAYISI; i++) begin
      kat_bit[i]  = (i == int'(kat_q));
      yeni_bit[i] = (i == int'(yeni_kat));
      if (istek[i]) begin
        if (i > int'(kat_q)) ust_var = 1'b1;
        if (i < int'(kat_q)) alt_var = 1'b1;
        if (yon_q ? (i > int'(yeni_kat)) : (i < int'(yeni_kat))) ileri_var = 1'b1;
      end
    end
  end

  assign burada       = |(istek & kat_bit);
  assign yeni_burada  = |(istek & yeni_bit);
  assign buton_burada = |(buton & kat_bit);

  // Next-state logic for the idle / moving / door-open controller.
  always_comb begin
    durum_d = durum;
    timer_d = timer;
    kat_d   = kat_q;
    durak_d = durak_q;
    yon_d   = yon_q;
    temizle = '0;
    case (durum)
      BOSTA: begin
        if (burada) begin
          durum_d = KAPI;
          durak_d = kat_q;
          timer_d = KAPI_YUK;
          temizle = kat_bit;
        end else if (ust_var && (yon_q || !alt_var)) begin
          yon_d   = 1'b1;
          durum_d = HAREKET;
          timer_d = HAREKET_YUK;
        end else if (alt_var) begin
          yon_d   = 1'b0;
          durum_d = HAREKET;
          timer_d = HAREKET_YUK;
        end
      end
      HAREKET: begin
        if (timer == '0) begin
          kat_d = yeni_kat;
          if (yeni_burada) begin
            durum_d = KAPI;
            durak_d = yeni_kat;
            timer_d = KAPI_YUK;
            temizle = yeni_bit;
          end else if (ileri_var) begin
            timer_d = HAREKET_YUK;
          end else begin
            durum_d = BOSTA;
          end
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end
      KAPI: begin
        temizle = kat_bit;
        if (buton_burada) begin
          timer_d = KAPI_YUK;
        end else if (timer == '0) begin
          durum_d = BOSTA;
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end
      default: begin
        durum_d = BOSTA;
        timer_d = '0;
      end
    endcase
  end

  // State registers; reset drops every pending request and parks the car at floor 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      durum      <= BOSTA;
      timer      <= '0;
      kat_q      <= '0;
      durak_q    <= '0;
      yon_q      <= 1'b1;
      bekleyen_q <= '0;
    end else begin
      durum      <= durum_d;
      timer      <= timer_d;
      kat_q      <= kat_d;
      durak_q    <= durak_d;
      yon_q      <= yon_d;
      bekleyen_q <= istek & ~temizle;
    end
  end

  assign mevcut_kat  = kat_q;
  assign durdugu_kat = durak_q;
  assign hareket     = (durum == HAREKET);
  assign kapi_acik   = (durum == KAPI);
  assign yon         = yon_q;
  assign bekleyen    = bekleyen_q;

endmodule

// File: tb/tb_asansor_kontrol.sv
// tb_asansor_kontrol: scoreboard bench for the elevator controller.
// A deadline-based reference model predicts every cycle's outputs and every
// door opening; a monitor pops those predictions and compares them.
module tb_asansor_kontrol;

  localparam int KAT = 4;
  localparam int HS  = 4;
  localparam int KS  = 3;

  logic           clk;
  logic           rst_n;
  logic [KAT-1:0] buton;
  logic [1:0]     mevcut_kat;
  logic [1:0]     durdugu_kat;
  logic           hareket;
  logic           yon;
  logic           kapi_acik;
  logic [KAT-1:0] bekleyen;

  asansor_kontrol #(
    .KAT_SAYISI  (KAT),
    .KAT_W       (2),
    .HAREKET_SURE(HS),
    .KAPI_SURE   (KS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buton      (buton),
    .mevcut_kat (mevcut_kat),
    .durdugu_kat(durdugu_kat),
    .hareket    (hareket),
    .yon        (yon),
    .kapi_acik  (kapi_acik),
    .bekleyen   (bekleyen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       kat;
    int       durak;
    bit       har;
    bit       yon;
    bit       kapi;
    bit [KAT-1:0] bek;
  } snap_t;

  snap_t exp_q[$];
  int    stop_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: position, pending set and absolute-cycle deadlines.
  int           m_pos, m_stop, m_dir, m_edge, m_arrive_at, m_close_at;
  bit           m_moving, m_door;
  bit [KAT-1:0] m_pend;

  function automatic bit any_req(input bit [KAT-1:0] r, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < KAT && r[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_stop = 0; m_dir = 1;
    m_moving = 0; m_door = 0; m_pend = '0;
  endtask

  task automatic model_open();
    m_door     = 1;
    m_moving   = 0;
    m_stop     = m_pos;
    m_close_at = m_edge + KS;
    stop_q.push_back(m_pos);
  endtask

  task automatic model_step(input bit [KAT-1:0] b, input bit r);
    bit [KAT-1:0] req;
    bit up, dn;
    snap_t s;
    m_edge++;
    if (!r) begin
      model_reset();
    end else begin
      req = m_pend | b;
      if (m_door) begin
        if (b[m_pos]) m_close_at = m_edge + KS;
        else if (m_edge == m_close_at) m_door = 0;
        req[m_pos] = 1'b0;
      end else if (m_moving) begin
        if (m_edge == m_arrive_at) begin
          m_pos = m_pos + (m_dir ? 1 : -1);
          if (req[m_pos]) begin
            model_open();
            req[m_pos] = 1'b0;
          end else if (m_dir ? any_req(req, m_pos + 1, KAT - 1) : any_req(req, 0, m_pos - 1)) begin
            m_arrive_at = m_edge + HS;
          end else begin
            m_moving = 0;
          end
        end
      end else begin
        if (req[m_pos]) begin
          model_open();
          req[m_pos] = 1'b0;
        end else begin
          up = any_req(req, m_pos + 1, KAT - 1);
          dn = any_req(req, 0, m_pos - 1);
          if (up && (m_dir == 1 || !dn)) begin
            m_dir = 1; m_moving = 1; m_arrive_at = m_edge + HS;
          end else if (dn) begin
            m_dir = 0; m_moving = 1; m_arrive_at = m_edge + HS;
          end
        end
      end
      m_pend = req;
    end
    s.kat = m_pos; s.durak = m_stop; s.har = m_moving; s.yon = (m_dir == 1);
    s.kapi = m_door; s.bek = m_pend;
    exp_q.push_back(s);
  endtask

  // Drive one cycle of inputs, let the edge consume them, record the prediction.
  task automatic applyStimulus(input logic [KAT-1:0] b, input logic r);
    buton = b;
    rst_n = r;
    @(posedge clk);
    model_step(b, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared against
  // the oldest prediction; each door opening is also matched to a stop event.
  snap_t s_mon;
  logic  prev_kapi = 1'b0;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      s_mon = exp_q.pop_front();
      checkOutput("mevcut_kat",  32'(mevcut_kat),  32'(s_mon.kat));
      checkOutput("durdugu_kat", 32'(durdugu_kat), 32'(s_mon.durak));
      checkOutput("hareket",     32'(hareket),     32'(s_mon.har));
      checkOutput("yon",         32'(yon),         32'(s_mon.yon));
      checkOutput("kapi_acik",   32'(kapi_acik),   32'(s_mon.kapi));
      checkOutput("bekleyen",    32'(bekleyen),    32'(s_mon.bek));
      if (kapi_acik === 1'b1 && prev_kapi !== 1'b1) begin
        if (stop_q.size() == 0)
          checkOutput("stop_event_unexpected", 32'(durdugu_kat), 32'hFFFF_FFFF);
        else
          checkOutput("stop_floor", 32'(durdugu_kat), 32'(stop_q.pop_front()));
      end
      prev_kapi = kapi_acik;
    end
  end

  logic [KAT-1:0] rb;

  initial begin
    buton = '0;
    rst_n = 1'b0;
    m_edge = 0;
    model_reset();

    $display("[TB] reset and idle");
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    idle(10);

    $display("[TB] single request to floor 2");
    applyStimulus(4'b0100, 1'b1);
    idle(20);

    $display("[TB] door held at floor 2");
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 1'b1);
    idle(10);

    $display("[TB] collective service 2,3 then 0");
    applyStimulus('0, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    idle(5);
    applyStimulus(4'b0101, 1'b1);
    idle(60);

    $display("[TB] reset while moving");
    applyStimulus('0, 1'b0);
    applyStimulus(4'b1010, 1'b1);
    idle(2);
    applyStimulus('0, 1'b0);
    idle(10);

    $display("[TB] pass floor 2 on the way to 3");
    applyStimulus(4'b1000, 1'b1);
    idle(5);
    applyStimulus(4'b1000, 1'b1);
    idle(30);

    $display("[TB] randomized traffic");
    rb = '0;
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 9))
        0:       rb = 4'($urandom_range(1, 15));
        1:       rb = rb;
        default: rb = '0;
      endcase
      applyStimulus(rb, ($urandom_range(0, 599) != 0));
    end
    idle(40);

    @(negedge clk);
    #1;
    checkOutput("pending_predictions", 32'(exp_q.size()), 32'd0);
    checkOutput("pending_stops",       32'(stop_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
